// File: rtl/atahost_pkg.sv
// ---------------------------------------------------------------------------
// atahost_pkg
//   Shared constants for the ATA host controller Wishbone slave:
//   internal register word offsets, CTRL/STAT bit positions, the revision
//   constant reported in STAT[31:24], the slave FSM state type and a
//   byte-lane merge helper used for Wishbone writes.
// ---------------------------------------------------------------------------
package atahost_pkg;

    // Internal register word offsets, i.e. byte address bits [5:2].
    localparam logic [3:0] ADR_CTRL = 4'h0;   // byte 0x00
    localparam logic [3:0] ADR_STAT = 4'h1;   // byte 0x04
    localparam logic [3:0] ADR_PCTR = 4'h2;   // byte 0x08

    // CTRL bit positions.
    localparam int CTRL_IDERST  = 0;
    localparam int CTRL_IORDYEN = 1;
    localparam int CTRL_IEN     = 2;
    localparam int CTRL_IDEEN   = 7;

    // STAT bit positions.
    localparam int STAT_IRQ     = 0;
    localparam int STAT_PIOBUSY = 7;

    // Revision constant reported in STAT[31:24].
    localparam logic [7:0] ATAHOST_REV = 8'h01;

    // Wishbone slave FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REG_ACK  = 2'd1,
        ST_PIO_WAIT = 2'd2,
        ST_PIO_ACK  = 2'd3
    } wb_state_t;

    // Replace the bytes of old_v whose select bit is set with bytes of new_v.
    function automatic logic [31:0] sel_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                r[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/atahost_wb_slave.sv
// ---------------------------------------------------------------------------
// atahost_wb_slave
//   Wishbone slave of the ATA host controller. Decodes internal registers
//   (CTRL, STAT, PCTR) and forwards ATA device register accesses to the PIO
//   command-port core as a request/acknowledge transaction.
//
//   Handshakes:
//     Wishbone : a request is wb_cyc_i & wb_stb_i sampled in IDLE. The slave
//                answers with exactly one single-cycle pulse of wb_ack_o or
//                wb_err_o; the master drops wb_stb_i once it sees it.
//     PIO core : PIOreq rises with PIOa/PIOd/PIOwe and all four stay stable
//                until PIOack is sampled high; PIOq is valid with PIOack.
//
//   Ports:
//     clk, nReset          master clock, asynchronous active-low reset
//     wb_*                 Wishbone slave (wb_adr_i = byte address [6:2])
//     wb_inta_o            registered interrupt (STAT.IRQ & CTRL.IEN)
//     IDEctrl_rst/IDEen    CTRL register outputs to the core
//     PIO_cmdport_*        PIO timing (PCTR) and IORDY enable to the core
//     PIOreq/PIOack/PIOa/PIOd/PIOq/PIOwe   PIO command port transaction
//     irq                  synchronized device interrupt
//     dbg_state_o          current slave FSM state
// ---------------------------------------------------------------------------
module atahost_wb_slave
    import atahost_pkg::*;
#(
    parameter logic [7:0] PIO_mode0_T1   = 8'd6,
    parameter logic [7:0] PIO_mode0_T2   = 8'd28,
    parameter logic [7:0] PIO_mode0_T4   = 8'd2,
    parameter logic [7:0] PIO_mode0_Teoc = 8'd23
) (
    input  logic        clk,
    input  logic        nReset,

    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_inta_o,

    output logic        IDEctrl_rst,
    output logic        IDEctrl_IDEen,
    output logic [7:0]  PIO_cmdport_T1,
    output logic [7:0]  PIO_cmdport_T2,
    output logic [7:0]  PIO_cmdport_T4,
    output logic [7:0]  PIO_cmdport_Teoc,
    output logic        PIO_cmdport_IORDYen,
    output logic        PIOreq,
    input  logic        PIOack,
    output logic [3:0]  PIOa,
    output logic [15:0] PIOd,
    input  logic [15:0] PIOq,
    output logic        PIOwe,
    input  logic        irq,

    output wb_state_t   dbg_state_o
);

    localparam logic [31:0] PCTR_RESET =
        {PIO_mode0_Teoc, PIO_mode0_T4, PIO_mode0_T2, PIO_mode0_T1};

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    wb_state_t   state_q;
    logic [31:0] wb_dat_q;
    logic        ack_q;
    logic        err_q;
    logic        inta_q;

    logic        ide_rst_q;
    logic        iordy_en_q;
    logic        ien_q;
    logic        ide_en_q;
    logic [31:0] pctr_q;
    logic        stat_irq_q;
    logic        irq_q;

    logic        pio_req_q;
    logic [3:0]  pio_a_q;
    logic [15:0] pio_d_q;
    logic        pio_we_q;

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    logic        wb_req_d;
    logic        dev_sel_d;     // byte address bit 6: ATA device register
    logic [3:0]  reg_idx_d;
    logic [31:0] rd_data_d;
    logic        irq_rise_d;
    logic        stat_clr_d;

    assign wb_req_d   = wb_cyc_i & wb_stb_i;
    assign dev_sel_d  = wb_adr_i[4];
    assign reg_idx_d  = wb_adr_i[3:0];
    assign irq_rise_d = irq & ~irq_q;

    // A STAT write with byte lane 0 enabled and bit0 = 0 clears IRQ.
    assign stat_clr_d = (state_q == ST_IDLE) & wb_req_d & ~dev_sel_d & wb_we_i &
                        (reg_idx_d == ADR_STAT) & wb_sel_i[0] & ~wb_dat_i[STAT_IRQ];

    // Internal register read mux; unmapped offsets read as zero.
    always_comb begin
        rd_data_d = 32'h0;
        case (reg_idx_d)
            ADR_CTRL: begin
                rd_data_d[CTRL_IDERST]  = ide_rst_q;
                rd_data_d[CTRL_IORDYEN] = iordy_en_q;
                rd_data_d[CTRL_IEN]     = ien_q;
                rd_data_d[CTRL_IDEEN]   = ide_en_q;
            end
            ADR_STAT: begin
                rd_data_d[STAT_IRQ]     = stat_irq_q;
                rd_data_d[STAT_PIOBUSY] = (state_q == ST_PIO_WAIT);
                rd_data_d[31:24]        = ATAHOST_REV;
            end
            ADR_PCTR: begin
                rd_data_d = pctr_q;
            end
            default: begin
                rd_data_d = 32'h0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Slave FSM, registers and interrupt
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            wb_dat_q   <= 32'h0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            inta_q     <= 1'b0;
            ide_rst_q  <= 1'b1;
            iordy_en_q <= 1'b0;
            ien_q      <= 1'b0;
            ide_en_q   <= 1'b0;
            pctr_q     <= PCTR_RESET;
            stat_irq_q <= 1'b0;
            irq_q      <= 1'b0;
            pio_req_q  <= 1'b0;
            pio_a_q    <= 4'h0;
            pio_d_q    <= 16'h0;
            pio_we_q   <= 1'b0;
        end else begin
            // Interrupt: a new rising edge wins over a simultaneous clear.
            irq_q <= irq;
            if (irq_rise_d) begin
                stat_irq_q <= 1'b1;
            end else if (stat_clr_d) begin
                stat_irq_q <= 1'b0;
            end
            inta_q <= stat_irq_q & ien_q;

            case (state_q)
                ST_IDLE: begin
                    if (wb_req_d) begin
                        if (!dev_sel_d) begin
                            // Internal register access, answered next cycle.
                            wb_dat_q <= rd_data_d;
                            ack_q    <= 1'b1;
                            state_q  <= ST_REG_ACK;
                            if (wb_we_i) begin
                                case (reg_idx_d)
                                    ADR_CTRL: begin
                                        if (wb_sel_i[0]) begin
                                            ide_rst_q  <= wb_dat_i[CTRL_IDERST];
                                            iordy_en_q <= wb_dat_i[CTRL_IORDYEN];
                                            ien_q      <= wb_dat_i[CTRL_IEN];
                                            ide_en_q   <= wb_dat_i[CTRL_IDEEN];
                                        end
                                    end
                                    ADR_PCTR: begin
                                        pctr_q <= sel_merge(pctr_q, wb_dat_i, wb_sel_i);
                                    end
                                    default: begin
                                        // STAT is handled with the interrupt
                                        // logic; other offsets ignore writes.
                                    end
                                endcase
                            end
                        end else if (wb_sel_i[1:0] == 2'b11) begin
                            // ATA device registers are 16 bits wide.
                            pio_req_q <= 1'b1;
                            pio_a_q   <= reg_idx_d;
                            pio_d_q   <= wb_dat_i[15:0];
                            pio_we_q  <= wb_we_i;
                            state_q   <= ST_PIO_WAIT;
                        end else begin
                            // Partial-width device access is refused.
                            err_q   <= 1'b1;
                            state_q <= ST_REG_ACK;
                        end
                    end
                end

                ST_REG_ACK: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end

                ST_PIO_WAIT: begin
                    // The ATA cycle always runs to completion; the ack is
                    // only given if the master is still in its cycle.
                    if (PIOack) begin
                        pio_req_q <= 1'b0;
                        pio_we_q  <= 1'b0;
                        wb_dat_q  <= {16'h0, PIOq};
                        ack_q     <= wb_cyc_i;
                        state_q   <= ST_PIO_ACK;
                    end
                end

                ST_PIO_ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign wb_dat_o            = wb_dat_q;
    assign wb_ack_o            = ack_q;
    assign wb_err_o            = err_q;
    assign wb_inta_o           = inta_q;

    assign IDEctrl_rst         = ide_rst_q;
    assign IDEctrl_IDEen       = ide_en_q;
    assign PIO_cmdport_IORDYen = iordy_en_q;
    assign PIO_cmdport_T1      = pctr_q[7:0];
    assign PIO_cmdport_T2      = pctr_q[15:8];
    assign PIO_cmdport_T4      = pctr_q[23:16];
    assign PIO_cmdport_Teoc    = pctr_q[31:24];

    assign PIOreq              = pio_req_q;
    assign PIOa                = pio_a_q;
    assign PIOd                = pio_d_q;
    assign PIOwe               = pio_we_q;

    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_atahost_wb_slave.sv
// ---------------------------------------------------------------------------
// tb_atahost_wb_slave
//   Directed bench for the ATA host Wishbone slave. The stimulus process
//   pushes the expected response of each Wishbone transfer into exp_q; the
//   monitor pops and compares on every wb_ack_o / wb_err_o pulse. A small
//   PIO core model answers PIO requests after a programmable latency and
//   checks that the request fields stay stable while it waits.
// ---------------------------------------------------------------------------
module tb_atahost_wb_slave;
  import atahost_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_adr_i = 5'h0;
  logic [3:0]  wb_sel_i = 4'h0;
  logic [31:0] wb_dat_i = 32'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_inta_o;
  logic        IDEctrl_rst, IDEctrl_IDEen;
  logic [7:0]  PIO_cmdport_T1, PIO_cmdport_T2, PIO_cmdport_T4, PIO_cmdport_Teoc;
  logic        PIO_cmdport_IORDYen;
  logic        PIOreq;
  logic        PIOack = 1'b0;
  logic [3:0]  PIOa;
  logic [15:0] PIOd;
  logic [15:0] PIOq = 16'h0;
  logic        PIOwe;
  logic        irq = 1'b0;
  wb_state_t   dbg_state;

  atahost_wb_slave dut (
    .clk                 (clk),
    .nReset              (nReset),
    .wb_cyc_i            (wb_cyc_i),
    .wb_stb_i            (wb_stb_i),
    .wb_we_i             (wb_we_i),
    .wb_adr_i            (wb_adr_i),
    .wb_sel_i            (wb_sel_i),
    .wb_dat_i            (wb_dat_i),
    .wb_dat_o            (wb_dat_o),
    .wb_ack_o            (wb_ack_o),
    .wb_err_o            (wb_err_o),
    .wb_inta_o           (wb_inta_o),
    .IDEctrl_rst         (IDEctrl_rst),
    .IDEctrl_IDEen       (IDEctrl_IDEen),
    .PIO_cmdport_T1      (PIO_cmdport_T1),
    .PIO_cmdport_T2      (PIO_cmdport_T2),
    .PIO_cmdport_T4      (PIO_cmdport_T4),
    .PIO_cmdport_Teoc    (PIO_cmdport_Teoc),
    .PIO_cmdport_IORDYen (PIO_cmdport_IORDYen),
    .PIOreq              (PIOreq),
    .PIOack              (PIOack),
    .PIOa                (PIOa),
    .PIOd                (PIOd),
    .PIOq                (PIOq),
    .PIOwe               (PIOwe),
    .irq                 (irq),
    .dbg_state_o         (dbg_state)
  );

  // scoreboard: {is_err, check_data, data}
  logic [33:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  // PIO core model controls and expected request fields
  int          dev_mute = 0;
  int          pio_lat = 1;
  logic [15:0] pio_rdata = 16'h0;
  logic [3:0]  exp_pioa = 4'h0;
  logic [15:0] exp_piod = 16'h0;
  logic        exp_piowe = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compares every response pulse against the scoreboard
  initial begin : monitor
    logic prev_resp;
    logic [33:0] e;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
        check32("ack_err_exclusive", 32'(wb_ack_o & wb_err_o), 32'h0);
        check32("resp_not_consecutive", 32'(prev_resp), 32'h0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_resp: got ack=%b err=%b expected none", wb_ack_o, wb_err_o);
        end else begin
          e = exp_q.pop_front();
          check32("resp_is_err", 32'(wb_err_o), 32'(e[33]));
          if (e[32]) check32("rd_data", wb_dat_o, e[31:0]);
        end
      end
      prev_resp = (wb_ack_o === 1'b1) || (wb_err_o === 1'b1);
    end
  end

  // PIO core model
  initial begin : pio_core
    logic ok;
    forever begin
      @(negedge clk);
      if (PIOreq === 1'b1 && dev_mute == 0 && PIOack == 1'b0) begin
        ok = 1'b1;
        for (int i = 0; i < pio_lat; i++) begin
          if (PIOreq !== 1'b1 || PIOa !== exp_pioa || PIOd !== exp_piod || PIOwe !== exp_piowe)
            ok = 1'b0;
          @(negedge clk);
        end
        check32("pio_req_stable", 32'(ok), 32'h1);
        PIOq = pio_rdata;
        PIOack = 1'b1;
        @(negedge clk);
        PIOack = 1'b0;
        PIOq = 16'h0;
      end
    end
  end

  // driver: one Wishbone transfer, waits (bounded) for ack/err
  task automatic wb_xfer(input logic we, input logic [6:0] badr, input logic [3:0] sel,
                         input logic [31:0] dat, input logic exp_err, input logic chk,
                         input logic [31:0] exp_dat, input int exp_wait, input logic irq_now);
    int waited;
    exp_q.push_back({exp_err, chk, exp_dat});
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = badr[6:2];
    wb_sel_i = sel;
    wb_dat_i = dat;
    if (irq_now) irq = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(wb_ack_o === 1'b1 || wb_err_o === 1'b1) && waited < 200);
    check32("resp_latency", 32'(waited), 32'(exp_wait));
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic reg_wr(input logic [6:0] badr, input logic [3:0] sel, input logic [31:0] dat);
    wb_xfer(1'b1, badr, sel, dat, 1'b0, 1'b0, 32'h0, 1, 1'b0);
  endtask

  task automatic reg_rd(input logic [6:0] badr, input logic [31:0] exp);
    wb_xfer(1'b0, badr, 4'hF, 32'h0, 1'b0, 1'b1, exp, 1, 1'b0);
  endtask

  initial begin : stimulus
    // reset state
    repeat (3) @(negedge clk);
    check32("rst_ack", 32'(wb_ack_o), 32'h0);
    check32("rst_err", 32'(wb_err_o), 32'h0);
    check32("rst_inta", 32'(wb_inta_o), 32'h0);
    check32("rst_pioreq", 32'(PIOreq), 32'h0);
    check32("rst_piowe", 32'(PIOwe), 32'h0);
    check32("rst_dat", wb_dat_o, 32'h0);
    check32("rst_ctrl_out", {IDEctrl_IDEen, PIO_cmdport_IORDYen, IDEctrl_rst}, 32'h1);
    check32("rst_timing", {PIO_cmdport_Teoc, PIO_cmdport_T4, PIO_cmdport_T2, PIO_cmdport_T1},
            32'h1702_1C06);
    check32("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    // register reads after reset
    reg_rd(7'h08, 32'h1702_1C06);
    reg_rd(7'h00, 32'h0000_0001);
    reg_rd(7'h04, 32'h0100_0000);

    // CTRL write
    reg_wr(7'h00, 4'hF, 32'h0000_0086);
    check32("ctrl_outputs", {IDEctrl_IDEen, PIO_cmdport_IORDYen, IDEctrl_rst}, 32'h6);
    reg_rd(7'h00, 32'h0000_0086);

    // PCTR byte-lane write
    reg_wr(7'h08, 4'b0101, 32'hAABB_CCDD);
    check32("pctr_lanes", {PIO_cmdport_Teoc, PIO_cmdport_T4, PIO_cmdport_T2, PIO_cmdport_T1},
            32'h17BB_1CDD);
    reg_rd(7'h08, 32'h17BB_1CDD);

    // unmapped internal offsets
    reg_wr(7'h10, 4'hF, 32'hFFFF_FFFF);
    reg_rd(7'h10, 32'h0);
    reg_rd(7'h3C, 32'h0);

    // PIO write, 40-cycle core latency
    exp_pioa = 4'h7; exp_piod = 16'h00EC; exp_piowe = 1'b1; pio_lat = 40; pio_rdata = 16'h0;
    wb_xfer(1'b1, 7'h5C, 4'hF, 32'h0000_00EC, 1'b0, 1'b0, 32'h0, 42, 1'b0);

    // PIO read
    exp_pioa = 4'h0; exp_piod = 16'h0; exp_piowe = 1'b0; pio_lat = 5; pio_rdata = 16'hA55A;
    wb_xfer(1'b0, 7'h40, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0000_A55A, 7, 1'b0);

    // partial-width PIO access is refused
    wb_xfer(1'b0, 7'h44, 4'hC, 32'h0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
    check32("err_no_pioreq", 32'(PIOreq), 32'h0);
    @(negedge clk);
    check32("err_no_pioreq_later", 32'(PIOreq), 32'h0);

    // interrupt (IEN set by the CTRL write above)
    irq = 1'b1;
    repeat (3) @(negedge clk);
    check32("inta_set", 32'(wb_inta_o), 32'h1);
    reg_rd(7'h04, 32'h0100_0001);
    reg_wr(7'h04, 4'h1, 32'h0);
    repeat (2) @(negedge clk);
    check32("inta_cleared", 32'(wb_inta_o), 32'h0);
    reg_rd(7'h04, 32'h0100_0000);
    irq = 1'b0;
    repeat (3) @(negedge clk);
    // clear on the same cycle as a new rising edge: set wins
    wb_xfer(1'b1, 7'h04, 4'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1, 1'b1);
    reg_rd(7'h04, 32'h0100_0001);
    check32("inta_set_wins", 32'(wb_inta_o), 32'h1);
    irq = 1'b0;

    // master abandons the cycle during PIO_WAIT: no ack, ATA cycle completes
    exp_pioa = 4'h3; exp_piod = 16'h1234; exp_piowe = 1'b1; pio_lat = 10;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 5'h13; wb_sel_i = 4'hF; wb_dat_i = 32'h0000_1234;
    repeat (3) @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    repeat (15) @(negedge clk);
    check32("drop_pioreq", 32'(PIOreq), 32'h0);
    check32("drop_state", 32'(dbg_state), 32'(ST_IDLE));
    reg_rd(7'h00, 32'h0000_0086);

    // reset in the middle of a PIO access
    dev_mute = 1;
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 5'h10; wb_sel_i = 4'h3; wb_dat_i = 32'h0;
    repeat (4) @(negedge clk);
    check32("midpio_pioreq", 32'(PIOreq), 32'h1);
    nReset = 1'b0;
    #1;
    check32("midpio_rst_pioreq", 32'(PIOreq), 32'h0);
    check32("midpio_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check32("midpio_rst_ctrl", 32'(IDEctrl_rst), 32'h1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    repeat (5) @(negedge clk);
    check32("midpio_after_pioreq", 32'(PIOreq), 32'h0);
    dev_mute = 0;
    reg_rd(7'h00, 32'h0000_0001);

    repeat (3) @(negedge clk);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/atahost_wb_slave.md
ATAHOST_WB_SLAVE -- requirements
Module: atahost_wb_slave

Interface
REQ-001 Parameter PIO_mode0_T1, default 6, reset value of the T1 field (70 ns @100 MHz).
REQ-002 Parameter PIO_mode0_T2, default 28, reset value of the T2 field.
REQ-003 Parameter PIO_mode0_T4, default 2, reset value of the T4 field.
REQ-004 Parameter PIO_mode0_Teoc, default 23, reset value of the Teoc field.
REQ-005 Ports: clk in 1, master clock; nReset in 1, asynchronous active-low reset; clock clk, reset nReset asynchronous active-low (already decided).
REQ-006 Wishbone slave ports: wb_cyc_i in 1; wb_stb_i in 1; wb_we_i in 1; wb_adr_i in 5 (byte address bits [6:2]); wb_sel_i in 4; wb_dat_i in 32; wb_dat_o out 32; wb_ack_o out 1; wb_err_o out 1; wb_inta_o out 1, interrupt.
REQ-007 Core-side ports: IDEctrl_rst out 1; IDEctrl_IDEen out 1; PIO_cmdport_T1/T2/T4/Teoc out 8 each; PIO_cmdport_IORDYen out 1; PIOreq out 1; PIOack in 1; PIOa out 4; PIOd out 16; PIOq in 16; PIOwe out 1; irq in 1, synchronized device interrupt.

Function
REQ-008 Address map: wb_adr_i[6]=0 selects internal registers; wb_adr_i[6]=1 selects an ATA device register with PIOa = wb_adr_i[5:2].
REQ-009 CTRL @0x00: bit0 IDErst (reset 1), bit1 IORDYen (reset 0), bit2 IEN (reset 0), bit7 IDEen (reset 0); other bits read 0.
REQ-010 STAT @0x04: bit0 IRQ (sticky), bit7 PIObusy (RO, 1 while in PIO_WAIT), bits[31:24] = 8'h01 (RO); other bits read 0.
REQ-011 PCTR @0x08: [7:0] T1, [15:8] T2, [23:16] T4, [31:24] Teoc; reset from parameters.
REQ-012 Internal addresses 0x0C-0x3C: read 0, writes ignored, acknowledged normally.
REQ-013 Internal register writes honour wb_sel_i per byte lane.
REQ-014 FSM states IDLE, REG_ACK, PIO_WAIT, PIO_ACK; reset state IDLE.
REQ-015 IDLE, cyc&stb, adr[6]=0 -> REG_ACK; write/read performed in that transition; wb_ack_o high for exactly the REG_ACK cycle; REG_ACK -> IDLE.
REQ-016 IDLE, cyc&stb, adr[6]=1, wb_sel_i[1:0]=2'b11 -> PIO_WAIT; PIOreq=1, PIOa, PIOwe=wb_we_i, PIOd=wb_dat_i[15:0] registered the same edge.
REQ-017 IDLE, cyc&stb, adr[6]=1, wb_sel_i[1:0]!=2'b11 -> wb_err_o pulsed one cycle via REG_ACK path, no PIO request, no ack.
REQ-018 PIO_WAIT: PIOreq, PIOa, PIOd, PIOwe held stable until PIOack sampled 1; then PIOreq cleared, read data {16'h0,PIOq} latched, -> PIO_ACK.
REQ-019 PIO_ACK: wb_ack_o high exactly one cycle (only if wb_cyc_i still 1), -> IDLE.
REQ-020 Master dropping wb_cyc_i during PIO_WAIT shall not abort the ATA cycle; completion proceeds, ack suppressed.
REQ-021 wb_ack_o and wb_err_o never asserted simultaneously, never for two consecutive cycles.
REQ-022 STAT.IRQ set on rising edge of irq (one-cycle delayed copy); cleared by writing 0 to STAT bit0; set wins over simultaneous clear.
REQ-023 wb_inta_o = STAT.IRQ & CTRL.IEN, registered.
REQ-024 Core outputs IDEctrl_*, PIO_cmdport_* drive directly from CTRL/PCTR flops.

Reset
REQ-025 nReset low: FSM IDLE, PIOreq=0, PIOwe=0, PIOa=0, PIOd=0, wb_ack_o=0, wb_err_o=0, wb_inta_o=0, wb_dat_o=0, CTRL=0x01, STAT.IRQ=0, PCTR={23,2,28,6}.
REQ-026 Reset asserted mid-PIO drops PIOreq immediately; no ack after release.

Structure
REQ-027 Register offsets, CTRL bit positions and revision constant live in the shared atahost package.
REQ-028 Single flat module; no sub-module.

Verification
REQ-029 After reset read 0x08 -> wb_dat_o=0x1702_1C06; read 0x00 -> 0x0000_0001.
REQ-030 Write 0x00=0x0000_0086 -> IDEctrl_rst=0, IORDYen=1, IEN=1, IDEen=1, ack one cycle after stb.
REQ-031 PIO write adr 0x5C, data 0x00EC, sel 4'hF; core returns PIOack after 40 cycles -> PIOa=4'h7, PIOwe=1, PIOd=0x00EC stable until PIOack, wb_ack_o 1 cycle later.
REQ-032 PIO read adr 0x40, PIOq=0xA55A at PIOack -> wb_dat_o=0x0000_A55A with ack.
REQ-033 PIO access with sel=4'hC -> wb_err_o one pulse, PIOreq stays 0.
REQ-034 irq rising with IEN=1 -> wb_inta_o=1; write STAT=0 -> wb_inta_o=0; write 0 on same cycle as new edge -> IRQ stays 1.
